// File: rtl/pb_instr_sequencer.sv
// Fetch/decode/issue sequencer for the SIMD bf16 block; optional perf counters under PB_SEQ_PERF_EN.
// ALU op = 2+ALU_LAT cycles, memory op = 3+wait cycles; mem_req is held until mem_ack, abort wins over all.
module pb_instr_sequencer #(
    parameter int IADDR_W = 16,
    parameter int ALU_LAT = 2
) (
    input  logic               clock_i,
    input  logic               reset_n_i,
    input  logic               start_i,
    input  logic [IADDR_W-1:0] start_pc_i,
    input  logic               abort_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [IADDR_W-1:0] pc_o,
    output logic               imem_rd_o,
    output logic [IADDR_W-1:0] imem_addr_o,
    input  logic [31:0]        imem_data_i,
    output logic [31:0]        instr_o,
    output logic               alu_en_o,
    output logic               rf_we_o,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [15:0]        mem_addr_o,
`ifdef PB_SEQ_PERF_EN
    output logic [31:0]        instr_count_o,
    output logic [31:0]        stall_count_o,
`endif
    input  logic               mem_ack_i
);

    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CNT_W-1:0] ALU_LAST = CNT_W'(ALU_LAT - 1);

    localparam logic [3:0] OP_ALU   = 4'h0;
    localparam logic [3:0] OP_WRITE = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_JUMP  = 4'h3;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM
    } state_t;

    state_t             state_q;
    logic [IADDR_W-1:0] pc_q;
    logic [31:0]        instr_q;
    logic [CNT_W-1:0]   alu_cnt_q;
    logic               done_q;
    logic               err_q;
    logic               imem_rd_q;
    logic               alu_en_q;
    logic               rf_we_q;
    logic               mem_req_q;
    logic               mem_we_q;
    logic [15:0]        mem_addr_q;

    logic [3:0]         opcode_d;
    logic [IADDR_W-1:0] pc_inc_d;
    logic [CNT_W-1:0]   alu_cnt_nxt_d;
    logic               alu_last_d;
    logic               load_ack_d;

    assign opcode_d      = imem_data_i[31:28];
    assign pc_inc_d      = pc_q + IADDR_W'(1);
    assign alu_cnt_nxt_d = alu_cnt_q + CNT_W'(1);
    assign alu_last_d    = (alu_cnt_q == ALU_LAST);
    // Load data arrives with the ack, so its write strobe cannot be registered ahead of time.
    assign load_ack_d    = mem_req_q & ~mem_we_q & mem_ack_i & ~abort_i;

    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            instr_q    <= '0;
            alu_cnt_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            imem_rd_q  <= 1'b0;
            alu_en_q   <= 1'b0;
            rf_we_q    <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            done_q  <= 1'b0;
            rf_we_q <= 1'b0;
            if (abort_i) begin
                state_q   <= S_IDLE;
                imem_rd_q <= 1'b0;
                alu_en_q  <= 1'b0;
                mem_req_q <= 1'b0;
                mem_we_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            pc_q      <= start_pc_i;
                            err_q     <= 1'b0;
                            imem_rd_q <= 1'b1;
                            state_q   <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        imem_rd_q <= 1'b0;
                        state_q   <= S_DECODE;
                    end
                    S_DECODE: begin
                        instr_q <= imem_data_i;
                        case (opcode_d)
                            OP_ALU: begin
                                alu_en_q  <= 1'b1;
                                alu_cnt_q <= '0;
                                rf_we_q   <= (ALU_LAT == 1);
                                state_q   <= S_EXEC;
                            end
                            OP_WRITE: begin
                                mem_req_q  <= 1'b1;
                                mem_we_q   <= 1'b1;
                                mem_addr_q <= {imem_data_i[23:16], imem_data_i[7:0]};
                                state_q    <= S_MEM;
                            end
                            OP_LOAD: begin
                                mem_req_q  <= 1'b1;
                                mem_we_q   <= 1'b0;
                                mem_addr_q <= imem_data_i[15:0];
                                state_q    <= S_MEM;
                            end
                            OP_JUMP: begin
                                pc_q      <= imem_data_i[IADDR_W-1:0];
                                imem_rd_q <= 1'b1;
                                state_q   <= S_FETCH;
                            end
                            OP_HALT: begin
                                done_q  <= 1'b1;
                                state_q <= S_IDLE;
                            end
                            default: begin
                                err_q   <= 1'b1;
                                state_q <= S_IDLE;
                            end
                        endcase
                    end
                    S_EXEC: begin
                        if (alu_last_d) begin
                            alu_en_q  <= 1'b0;
                            pc_q      <= pc_inc_d;
                            imem_rd_q <= 1'b1;
                            state_q   <= S_FETCH;
                        end else begin
                            alu_cnt_q <= alu_cnt_nxt_d;
                            rf_we_q   <= (alu_cnt_nxt_d == ALU_LAST);
                        end
                    end
                    S_MEM: begin
                        if (mem_ack_i) begin
                            mem_req_q <= 1'b0;
                            mem_we_q  <= 1'b0;
                            pc_q      <= pc_inc_d;
                            imem_rd_q <= 1'b1;
                            state_q   <= S_FETCH;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign pc_o        = pc_q;
    assign imem_rd_o   = imem_rd_q;
    assign imem_addr_o = pc_q;
    assign instr_o     = instr_q;
    assign alu_en_o    = alu_en_q;
    assign rf_we_o     = rf_we_q | load_ack_d;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;

`ifdef PB_SEQ_PERF_EN
    logic        retire_d;
    logic        start_acc_d;
    logic        stall_d;
    logic [31:0] instr_count_q;
    logic [31:0] stall_count_q;

    // JUMP and HALT retire in DECODE; illegal opcodes and aborted ops never retire.
    always_comb begin
        retire_d = 1'b0;
        if (!abort_i) begin
            case (state_q)
                S_EXEC:   retire_d = alu_last_d;
                S_MEM:    retire_d = mem_ack_i;
                S_DECODE: retire_d = (opcode_d == OP_JUMP) || (opcode_d == OP_HALT);
                default:  retire_d = 1'b0;
            endcase
        end
    end

    assign start_acc_d = (state_q == S_IDLE) && start_i && !abort_i;
    assign stall_d     = mem_req_q && !mem_ack_i;

    always_ff @(posedge clock_i) begin
        if (!reset_n_i || start_acc_d) begin
            instr_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            if (retire_d && (instr_count_q != 32'hFFFF_FFFF)) begin
                instr_count_q <= instr_count_q + 32'd1;
            end
            if (stall_d && (stall_count_q != 32'hFFFF_FFFF)) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign instr_count_o = instr_count_q;
    assign stall_count_o = stall_count_q;
`endif

endmodule

// File: tb/tb_pb_instr_sequencer.sv
// Directed bench for pb_instr_sequencer (ALU_LAT=2, IADDR_W=16); cycle 0 is the first FETCH after start.
module tb_pb_instr_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] start_pc;
    logic        abort;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] pc;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic        alu_en;
    logic        rf_we;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic        mem_ack;

    logic [31:0] imem [0:65535];

    int total = 0;
    int bad   = 0;

    pb_instr_sequencer #(.IADDR_W(16), .ALU_LAT(2)) dut (
        .clock_i     (clk),
        .reset_n_i   (reset_n),
        .start_i     (start),
        .start_pc_i  (start_pc),
        .abort_i     (abort),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .pc_o        (pc),
        .imem_rd_o   (imem_rd),
        .imem_addr_o (imem_addr),
        .imem_data_i (imem_data),
        .instr_o     (instr),
        .alu_en_o    (alu_en),
        .rf_we_o     (rf_we),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_ack_i   (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (imem_rd) imem_data <= imem[imem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_at(input logic [15:0] a);
        start    = 1'b1;
        start_pc = a;
        tick();
        start    = 1'b0;
    endtask

    logic [15:0] rf_hist, done_hist, req_hist, alu_hist, rd_hist;
    logic        any_rf, any_req;

    initial begin
        for (int i = 0; i < 65536; i++) imem[i] = 32'h0;
        imem_data = 32'h0;
        reset_n   = 1'b0;
        start     = 1'b0;
        start_pc  = 16'h0;
        abort     = 1'b0;
        mem_ack   = 1'b0;

        imem[16'h0000] = 32'h01030102;  // ALU
        imem[16'h0001] = 32'h20050040;  // LOAD r5 <- [0x0040]
        imem[16'h0002] = 32'hF0000000;  // HALT
        imem[16'h0005] = 32'h30000010;  // JUMP 0x0010
        imem[16'h0010] = 32'hF0000000;  // HALT
        imem[16'hFFFF] = 32'h00000000;  // ALU at top of address space
        imem[16'h0020] = 32'h70000000;  // illegal
        imem[16'h0030] = 32'h20050040;  // LOAD

        // Power-up reset
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_imem_rd", 32'(imem_rd), 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_outs", {26'h0, alu_en, rf_we, mem_req, mem_we, 2'b00}, 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        reset_n = 1'b1;
        tick();

        // ALU, LOAD with ack withheld until cycle 9, HALT; stray ack in cycle 4 must be ignored
        rf_hist = '0; done_hist = '0; req_hist = '0; alu_hist = '0; rd_hist = '0;
        start_at(16'h0000);
        for (int c = 0; c < 13; c++) begin
            mem_ack = (c == 4) || (c == 9);
            #1;
            rf_hist[c]   = rf_we;
            done_hist[c] = done;
            req_hist[c]  = mem_req;
            alu_hist[c]  = alu_en;
            rd_hist[c]   = imem_rd;
            if (c == 2) chk("t2_instr_alu", instr, 32'h01030102);
            if (c == 6) begin
                chk("t2_instr_load", instr, 32'h20050040);
                chk("t2_mem_addr", 32'(mem_addr), 32'h0040);
                chk("t2_mem_we", 32'(mem_we), 32'h0);
            end
            if (c == 12) begin
                chk("t2_busy_end", 32'(busy), 32'h0);
                chk("t2_pc_end", 32'(pc), 32'h0002);
            end
            tick();
        end
        mem_ack = 1'b0;
        chk("t2_rf_we_cycles", 32'(rf_hist), 32'h0208);
        chk("t2_done_cycles", 32'(done_hist), 32'h1000);
        chk("t2_mem_req_cycles", 32'(req_hist), 32'h03C0);
        chk("t2_alu_en_cycles", 32'(alu_hist), 32'h000C);
        chk("t2_imem_rd_cycles", 32'(rd_hist), 32'h0411);

        // JUMP 0x0010 from 0x0005
        any_rf = 1'b0; any_req = 1'b0;
        start_at(16'h0005);
        for (int c = 0; c < 5; c++) begin
            any_rf  = any_rf | rf_we;
            any_req = any_req | mem_req;
            if (c == 2) begin
                chk("t3_imem_addr", 32'(imem_addr), 32'h0010);
                chk("t3_imem_rd", 32'(imem_rd), 32'h1);
            end
            if (c == 4) chk("t3_done", 32'(done), 32'h1);
            tick();
        end
        chk("t3_no_rf_we", 32'(any_rf), 32'h0);
        chk("t3_no_mem_req", 32'(any_req), 32'h0);

        // ALU at 0xFFFF: pc wraps to 0
        imem[16'h0000] = 32'hF0000000;
        start_at(16'hFFFF);
        for (int c = 0; c < 7; c++) begin
            if (c == 3) chk("t4_rf_we", 32'(rf_we), 32'h1);
            if (c == 4) begin
                chk("t4_wrap_addr", 32'(imem_addr), 32'h0000);
                chk("t4_wrap_rd", 32'(imem_rd), 32'h1);
            end
            if (c == 6) chk("t4_done", 32'(done), 32'h1);
            tick();
        end

        // Illegal opcode 0x7
        any_rf = 1'b0; any_req = 1'b0;
        start_at(16'h0020);
        for (int c = 0; c < 4; c++) begin
            any_rf  = any_rf | rf_we;
            any_req = any_req | mem_req;
            if (c == 2) begin
                chk("t5_err", 32'(err), 32'h1);
                chk("t5_busy", 32'(busy), 32'h0);
                chk("t5_no_done", 32'(done), 32'h0);
            end
            tick();
        end
        chk("t5_no_rf_we", 32'(any_rf), 32'h0);
        chk("t5_no_mem_req", 32'(any_req), 32'h0);
        chk("t5_err_sticky", 32'(err), 32'h1);
        start_at(16'h0010);
        chk("t5_err_cleared", 32'(err), 32'h0);
        tick();
        tick();
        chk("t5_halt_done", 32'(done), 32'h1);
        tick();

        // Abort while mem_req waits; start while busy is ignored
        start_at(16'h0030);
        tick();
        tick();
        chk("t6_req_up", 32'(mem_req), 32'h1);
        start    = 1'b1;
        start_pc = 16'h0055;
        tick();
        start = 1'b0;
        chk("t6_busy_start_ignored", 32'(busy), 32'h1);
        chk("t6_pc_start_ignored", 32'(pc), 32'h0030);
        chk("t6_req_held", 32'(mem_req), 32'h1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_abort_req", 32'(mem_req), 32'h0);
        chk("t6_abort_busy", 32'(busy), 32'h0);
        chk("t6_abort_pc", 32'(pc), 32'h0030);
        chk("t6_abort_no_done", 32'(done), 32'h0);
        chk("t6_abort_rf_we", 32'(rf_we), 32'h0);
        tick();
        chk("t6_idle_stays", 32'({busy, imem_rd}), 32'h0);
        start    = 1'b1;
        abort    = 1'b1;
        start_pc = 16'h0010;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("t6_abort_beats_start", 32'(busy), 32'h0);
        chk("t6_abort_beats_start_pc", 32'(pc), 32'h0030);

        // Reset held two cycles in the middle of a memory wait
        start_at(16'h0030);
        tick();
        tick();
        chk("t1_req_before", 32'(mem_req), 32'h1);
        reset_n = 1'b0;
        tick();
        chk("t1_busy", 32'(busy), 32'h0);
        chk("t1_mem_req", 32'(mem_req), 32'h0);
        chk("t1_pc", 32'(pc), 32'h0);
        chk("t1_instr", instr, 32'h0);
        chk("t1_mem_addr", 32'(mem_addr), 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("t1_idle_after", 32'(busy), 32'h0);
        start_at(16'h0010);
        tick();
        tick();
        chk("t1_run_after_reset", 32'(done), 32'h1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
